// File: rtl/clk_monitor_pkg.sv
// rtl/clk_monitor_pkg.sv - shared constants, state encoding and range helper for clock_monitor_10hz
//
// Contents:
//   CNT_W / FAULT_W       : period counter and fault counter widths
//   *_DEF                 : default NOMINAL, TOL, TIMEOUT and LOCK_COUNT values
//   ST_*                  : monitor state encoding
//   in_range()            : inclusive window test on a measured period
package clk_monitor_pkg;

  localparam int CNT_W          = 18;
  localparam int FAULT_W        = 8;

  localparam int NOMINAL_DEF    = 100000;
  localparam int TOL_DEF        = 500;
  localparam int TIMEOUT_DEF    = 150000;
  localparam int LOCK_COUNT_DEF = 3;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACQUIRE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;
  localparam logic [1:0] ST_LOST    = 2'd3;

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic logic in_range(input cnt_t period, input cnt_t lo, input cnt_t hi);
    return (period >= lo) && (period <= hi);
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - two-flop synchronizer with history flop and rising-edge pulse
//
// Ports:
//   clk_i   : sampling clock
//   rst_i   : asynchronous active-high reset
//   d_i     : asynchronous input
//   level_o : synchronized level (second synchronizer stage)
//   rise_o  : one-cycle pulse when the synchronized level goes 0 -> 1
module sync_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic hist_q;

  // All three flops come out of reset high so an input that is already
  // high when reset is released never looks like a fresh rise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign level_o = sync2_q;
  assign rise_o  = sync2_q & ~hist_q;

endmodule

// File: rtl/clock_monitor_10hz.sv
// rtl/clock_monitor_10hz.sv - period measurement, lock tracking and loss detection of a 10 Hz input
//
// Ports:
//   CLK_1MHZ_IN  : sole clock, rising edge
//   RESET        : asynchronous active-high reset
//   CLK_10HZ_IN  : monitored signal, asynchronous to CLK_1MHZ_IN
//   PERIOD_OUT   : last measured period in CLK_1MHZ_IN cycles
//   PERIOD_VALID : one-cycle pulse when PERIOD_OUT updates
//   LOCKED       : high in the LOCKED state
//   CLK_FAULT    : high in the LOST state
//   FAULT_COUNT  : saturating count of fault events
module clock_monitor_10hz
  import clk_monitor_pkg::*;
#(
  parameter int NOMINAL    = NOMINAL_DEF,
  parameter int TOL        = TOL_DEF,
  parameter int LOCK_COUNT = LOCK_COUNT_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic               CLK_1MHZ_IN,
  input  logic               RESET,
  input  logic               CLK_10HZ_IN,
  output logic [CNT_W-1:0]   PERIOD_OUT,
  output logic               PERIOD_VALID,
  output logic               LOCKED,
  output logic               CLK_FAULT,
  output logic [FAULT_W-1:0] FAULT_COUNT
);

  localparam int GOOD_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);

  localparam cnt_t              PERIOD_LO = cnt_t'(NOMINAL - TOL);
  localparam cnt_t              PERIOD_HI = cnt_t'(NOMINAL + TOL);
  localparam cnt_t              TIMEOUT_C = cnt_t'(TIMEOUT);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);

  logic                sync_level;
  logic                rise;
  logic                edge_det;
  logic                timeout;
  logic                period_ok;
  logic                fault_inc;
  cnt_t                period;

  cnt_t                cnt_q,    cnt_d;
  cnt_t                period_q, period_d;
  logic [1:0]          state_q,  state_d;
  logic [GOOD_W-1:0]   good_q,   good_d;
  logic                valid_q,  valid_d;
  logic [FAULT_W-1:0]  fault_q,  fault_d;

  sync_edge_detect u_sync (
    .clk_i   (CLK_1MHZ_IN),
    .rst_i   (RESET),
    .d_i     (CLK_10HZ_IN),
    .level_o (sync_level),
    .rise_o  (rise)
  );

  // rise already implies a high level; qualifying keeps the intent explicit.
  assign edge_det  = rise & sync_level;

  // The counter is cleared in the edge cycle, so counter+1 is the number of
  // clocks since the previous edge cycle.
  assign period    = cnt_q + cnt_t'(1);
  assign timeout   = (period == TIMEOUT_C) && !edge_det;
  assign period_ok = in_range(period, PERIOD_LO, PERIOD_HI);

  always_comb begin
    cnt_d = cnt_q;
    if (edge_det) begin
      cnt_d = '0;
    end else if (cnt_q < TIMEOUT_C) begin
      cnt_d = cnt_q + cnt_t'(1);
    end
  end

  // An edge always takes priority over a coincident timeout.
  always_comb begin
    state_d   = state_q;
    good_d    = good_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    fault_inc = 1'b0;
    if (edge_det) begin
      case (state_q)
        ST_IDLE, ST_LOST: begin
          // No trustworthy previous edge: this edge only starts a measurement.
          state_d = ST_ACQUIRE;
          good_d  = '0;
        end
        ST_ACQUIRE: begin
          period_d = period;
          valid_d  = 1'b1;
          if (period_ok) begin
            good_d = good_q + GOOD_W'(1);
            if (good_q >= GOOD_LAST) begin
              state_d = ST_LOCKED;
            end
          end else begin
            good_d    = '0;
            fault_inc = 1'b1;
          end
        end
        ST_LOCKED: begin
          period_d = period;
          valid_d  = 1'b1;
          if (!period_ok) begin
            state_d   = ST_LOST;
            fault_inc = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else if (timeout && (state_q != ST_LOST)) begin
      state_d   = ST_LOST;
      fault_inc = 1'b1;
    end
  end

  always_comb begin
    fault_d = fault_q;
    if (fault_inc && (fault_q != {FAULT_W{1'b1}})) begin
      fault_d = fault_q + FAULT_W'(1);
    end
  end

  always_ff @(posedge CLK_1MHZ_IN or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      good_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      fault_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      good_q   <= good_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      fault_q  <= fault_d;
    end
  end

  assign PERIOD_OUT   = period_q;
  assign PERIOD_VALID = valid_q;
  assign LOCKED       = (state_q == ST_LOCKED);
  assign CLK_FAULT    = (state_q == ST_LOST);
  assign FAULT_COUNT  = fault_q;

endmodule

// File: tb/tb_clock_monitor_10hz.sv
// tb/tb_clock_monitor_10hz.sv - self-checking bench for clock_monitor_10hz with scaled timing
module tb_clock_monitor_10hz;

  localparam int NOM = 100;
  localparam int TOL = 5;
  localparam int LCK = 3;
  localparam int TMO = 150;

  localparam int M_IDLE = 0;
  localparam int M_ACQ  = 1;
  localparam int M_LOCK = 2;
  localparam int M_LOST = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        sig_in;
  logic [17:0] period_out;
  logic        period_valid;
  logic        locked;
  logic        clk_fault;
  logic [7:0]  fault_count;

  int checks = 0;
  int errors = 0;

  int m_mode;
  int m_good;
  int m_faults;
  int m_period;
  int m_valid;

  always #5 clk = ~clk;

  clock_monitor_10hz #(
    .NOMINAL    (NOM),
    .TOL        (TOL),
    .LOCK_COUNT (LCK),
    .TIMEOUT    (TMO)
  ) dut (
    .CLK_1MHZ_IN  (clk),
    .RESET        (rst),
    .CLK_10HZ_IN  (sig_in),
    .PERIOD_OUT   (period_out),
    .PERIOD_VALID (period_valid),
    .LOCKED       (locked),
    .CLK_FAULT    (clk_fault),
    .FAULT_COUNT  (fault_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit accepted(input int p);
    int dev;
    dev = (p > NOM) ? (p - NOM) : (NOM - p);
    return dev <= TOL;
  endfunction

  task automatic model_reset();
    m_mode   = M_IDLE;
    m_good   = 0;
    m_faults = 0;
    m_period = 0;
    m_valid  = 0;
  endtask

  task automatic model_fault();
    if (m_faults < 255) m_faults++;
  endtask

  // p = clocks since the previous rise of the input
  task automatic model_edge(input int p);
    m_valid = 0;
    if (m_mode == M_IDLE || m_mode == M_LOST) begin
      m_mode = M_ACQ;
      m_good = 0;
    end else begin
      m_valid  = 1;
      m_period = p;
      if (accepted(p)) begin
        if (m_mode == M_ACQ) begin
          m_good++;
          if (m_good == LCK) m_mode = M_LOCK;
        end
      end else begin
        model_fault();
        if (m_mode == M_ACQ) m_good = 0;
        else m_mode = M_LOST;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"},  {31'd0, period_valid}, m_valid);
    chk({tag, ".period"}, {14'd0, period_out},   m_period);
    chk({tag, ".locked"}, {31'd0, locked},       (m_mode == M_LOCK) ? 1 : 0);
    chk({tag, ".fault"},  {31'd0, clk_fault},    (m_mode == M_LOST) ? 1 : 0);
    chk({tag, ".fcount"}, {24'd0, fault_count},  m_faults);
  endtask

  // Raise the input at a falling clock edge; the DUT acts on the third rising
  // edge afterwards, so results are visible three falling edges later.
  task automatic rise_edge(input int p, input string tag);
    sig_in = 1'b1;
    model_edge(p);
    repeat (3) @(negedge clk);
    check_all(tag);
    @(negedge clk);
    chk({tag, ".pulse_end"}, {31'd0, period_valid}, 0);
  endtask

  // Complete the current period so the next rise is exactly p clocks after the last.
  task automatic step(input int p, input string tag);
    repeat (p / 2 - 4) @(negedge clk);
    sig_in = 1'b0;
    repeat (p - p / 2) @(negedge clk);
    rise_edge(p, tag);
  endtask

  initial begin
    int p;
    rst    = 1'b1;
    sig_in = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    rst = 1'b0;

    // Lock on four nominal edges.
    repeat (5) @(negedge clk);
    rise_edge(0, "first_edge");
    for (int i = 0; i < 3; i++) step(NOM, "lock");
    chk("lock.final", {31'd0, locked}, 1);

    // One slow period from LOCKED.
    step(NOM + 2 * TOL, "slow_period");
    chk("slow.fcount", {24'd0, fault_count}, 1);

    // Window boundaries in ACQUIRE, then a just-too-short period.
    step(NOM, "relaunch");
    step(NOM - TOL, "lo_bound");
    step(NOM + TOL, "hi_bound");
    step(NOM - TOL - 1, "below_lo");
    step(NOM, "reacq1");
    step(NOM, "reacq2");
    step(NOM, "reacq3");
    step(NOM + TOL, "locked_hi");
    step(NOM - TOL, "locked_lo");

    // Edge landing exactly on the timeout cycle is measured as a period.
    step(TMO, "edge_vs_timeout");
    for (int i = 0; i < 4; i++) step(NOM, "relock");

    // Input stuck low while LOCKED.
    sig_in = 1'b0;
    repeat (TMO - 2) @(negedge clk);
    chk("timeout.before", {31'd0, clk_fault}, 0);
    chk("timeout.before_locked", {31'd0, locked}, 1);
    @(negedge clk);
    m_mode  = M_LOST;
    m_valid = 0;
    model_fault();
    check_all("timeout.at");
    repeat (2 * TMO) @(negedge clk);
    check_all("timeout.held");

    // Recovery from LOST, then reset while LOCKED with the input high.
    rise_edge(TMO, "lost_edge");
    for (int i = 0; i < 3; i++) step(NOM, "relock2");
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_reset.valid",  {31'd0, period_valid}, 0);
      chk("post_reset.locked", {31'd0, locked},       0);
      chk("post_reset.fault",  {31'd0, clk_fault},    0);
    end
    sig_in = 1'b0;
    repeat (5) @(negedge clk);
    rise_edge(0, "post_reset_first");

    // Randomized periods across and around the acceptance window.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       p = int'($urandom_range(NOM - TOL, NOM + TOL));
        1:       p = int'($urandom_range(60, NOM - TOL - 1));
        2:       p = int'($urandom_range(NOM + TOL + 1, 140));
        default: p = NOM;
      endcase
      step(p, "random");
    end

    // Fault counter saturation.
    for (int i = 0; i < 300; i++) step(60, "sat");
    chk("sat.count", {24'd0, fault_count}, 255);
    for (int i = 0; i < 5; i++) step(60, "sat_hold");
    chk("sat.held", {24'd0, fault_count}, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_monitor_10hz.md
CLOCK_MONITOR_10HZ -- requirements
Module: clock_monitor_10hz

Interface
REQ-001 SHALL have parameter NOMINAL, default 100000, meaning the expected CLK_10HZ_IN period in CLK_1MHZ_IN cycles.
REQ-002 SHALL have parameter TOL, default 500, meaning the accepted deviation of a period from NOMINAL, in cycles.
REQ-003 SHALL have parameter LOCK_COUNT, default 3, meaning the number of consecutive in-range periods required to lock.
REQ-004 SHALL have parameter TIMEOUT, default 150000, meaning the number of cycles without an edge that declares loss of the 10 Hz input.
REQ-005 SHALL have port CLK_1MHZ_IN, input, 1 bit: the sole clock; all logic is on its rising edge.
REQ-006 SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port CLK_10HZ_IN, input, 1 bit: the 10 Hz signal under test, treated as asynchronous.
REQ-008 SHALL have port PERIOD_OUT, output, 18 bits: the last measured period in CLK_1MHZ_IN cycles.
REQ-009 SHALL have port PERIOD_VALID, output, 1 bit: a one-cycle pulse in the cycle PERIOD_OUT updates.
REQ-010 SHALL have port LOCKED, output, 1 bit: high only in the LOCKED state.
REQ-011 SHALL have port CLK_FAULT, output, 1 bit: high only in the LOST state.
REQ-012 SHALL have port FAULT_COUNT, output, 8 bits: saturating count of fault events.

Function
REQ-013 SHALL pass CLK_10HZ_IN through a two-flop synchronizer plus one history flop; an edge is detected when sync stage 2 is 1 and history is 0.
REQ-014 SHALL assert the edge-detect pulse on the third CLK_1MHZ_IN rising edge after the input rise.
REQ-015 SHALL run an 18-bit period counter that clears to 0 on an edge, increments otherwise, and saturates at TIMEOUT.
REQ-016 SHALL compute the measured period as counter+1, sampled in the edge cycle, so edges 100000 cycles apart measure 100000.
REQ-017 SHALL treat a period as in range when NOMINAL-TOL <= period <= NOMINAL+TOL, bounds inclusive.
REQ-018 SHALL implement four states: IDLE, ACQUIRE, LOCKED and LOST.
REQ-019 SHALL, from IDLE, go to ACQUIRE on the first edge, with no PERIOD_VALID because no prior edge exists.
REQ-020 SHALL, in ACQUIRE or LOCKED, load PERIOD_OUT and pulse PERIOD_VALID on every edge.
REQ-021 SHALL, in ACQUIRE, increment good_cnt on an in-range period and enter LOCKED when good_cnt reaches LOCK_COUNT.
REQ-022 SHALL, in ACQUIRE, clear good_cnt and increment FAULT_COUNT on an out-of-range period, staying in ACQUIRE.
REQ-023 SHALL, in LOCKED, remain in LOCKED on an in-range period.
REQ-024 SHALL, in LOCKED, go to LOST and increment FAULT_COUNT on an out-of-range period.
REQ-025 SHALL declare a timeout when counter+1 equals TIMEOUT with no edge in that cycle.
REQ-026 SHALL, on a timeout in IDLE, ACQUIRE or LOCKED, go to LOST and increment FAULT_COUNT once.
REQ-027 SHALL, in LOST, count no further timeouts.
REQ-028 SHALL, in LOST, treat an edge as the start of a new measurement: enter ACQUIRE, clear good_cnt, no PERIOD_VALID.
REQ-029 SHALL let an edge win over a timeout in the same cycle, so the period is evaluated normally.
REQ-030 SHALL hold FAULT_COUNT at 255 once it reaches 255.

Reset
REQ-031 SHALL, while RESET is high, immediately force state IDLE and PERIOD_OUT=0, PERIOD_VALID=0, LOCKED=0, CLK_FAULT=0, FAULT_COUNT=0, counter=0, good_cnt=0.
REQ-032 SHALL reset both synchronizer flops and the history flop to 1, so an input already high at reset release produces no edge.
REQ-033 SHALL start operation on the first CLK_1MHZ_IN rising edge after RESET falls.

Structure
REQ-034 SHALL place the NOMINAL/TOL/TIMEOUT defaults, the 18-bit counter width and the state encoding in the shared package clk_monitor_pkg.
REQ-035 SHALL implement the synchronizer and edge detector as sub-module sync_edge_detect, with outputs sync level and rise pulse.

Verification
REQ-036 SHALL cover: reset, then 4 rising edges 100000 cycles apart -> three PERIOD_VALID pulses with PERIOD_OUT=100000, LOCKED=1 after the 4th edge, CLK_FAULT=0.
REQ-037 SHALL cover: from LOCKED, one period of 101000 -> PERIOD_OUT=101000, LOCKED=0, CLK_FAULT=1, FAULT_COUNT=1.
REQ-038 SHALL cover: from LOCKED, input held low -> CLK_FAULT=1 exactly 150000 cycles after the last counter clear, with FAULT_COUNT incremented exactly once.
REQ-039 SHALL cover: periods 99500 and 100500 -> accepted; period 99499 -> good_cnt cleared and FAULT_COUNT incremented.
REQ-040 SHALL cover: RESET asserted mid-LOCKED with the input high -> all outputs 0 asynchronously, and no PERIOD_VALID or state change after release until a new rise.
REQ-041 SHALL cover: 300 out-of-range periods in ACQUIRE -> FAULT_COUNT=255, held.
